// File: rtl/ed25519_pkg.sv
// Shared Ed25519 constants and enums for the nonce sampler and the
// scalar-reduction datapath.
//   ED25519_L      : group order L = 2^252 + 0x14def9dea2f79cd65812631a5cf5d3ed
//   MASK253        : low 253 bits set
//   CLAMP_CLR/SET  : AND/OR masks that turn a raw word into an RFC 8032 scalar
//   nonce_mode_e   : CLAMP (0) or REDUCED (1)
//   sampler_state_e: sampler FSM states
package ed25519_pkg;

    localparam logic [255:0] ED25519_L =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    localparam logic [255:0] MASK253 = {3'b000, {253{1'b1}}};

    // Clamping clears bits 2:0 and bit 255, then forces bit 254.
    localparam logic [255:0] CLAMP_CLR = {1'b0, {252{1'b1}}, 3'b000};
    localparam logic [255:0] CLAMP_SET = {2'b01, 254'd0};

    typedef enum logic {
        CLAMP   = 1'b0,
        REDUCED = 1'b1
    } nonce_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        HOLD
    } sampler_state_e;

endpackage

// File: rtl/ed25519_lt_l.sv
// Combinational range check for a 253-bit scalar candidate.
//   m  : candidate, already masked to 253 bits
//   ok : 1 when m is nonzero and strictly below the group order L
module ed25519_lt_l
    import ed25519_pkg::*;
(
    input  logic [252:0] m,
    output logic         ok
);

    // L < 2^253, so comparing against its low 253 bits is exact.
    assign ok = (m != '0) && (m < ED25519_L[252:0]);

endmodule

// File: rtl/ed25519_nonce_sampler.sv
// Turns the free-running 256-bit LFSR word into an Ed25519 secret on request.
// The word is sampled only after FRESH_CYCLES cycles so that every bit has
// been shifted in since the request. CLAMP mode formats an RFC 8032 clamped
// scalar; REDUCED mode rejection-samples a scalar in [1, L-1], giving up with
// an err pulse after MAX_TRIES samples.
//   clk, rst   : clock, synchronous active-high reset
//   rng_data   : LFSR word
//   req, mode  : request (accepted only when idle) and mode captured with it
//   busy       : high whenever the sampler is not idle
//   out_valid/out_ready/out_data : result handshake, data stable while valid
//   tries      : samples taken for the current or last request
//   err        : one-cycle pulse when REDUCED mode runs out of tries
module ed25519_nonce_sampler
    import ed25519_pkg::*;
#(
    parameter int FRESH_CYCLES = 256,
    parameter int MAX_TRIES    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [255:0]                     rng_data,
    input  logic                             req,
    input  logic                             mode,
    output logic                             busy,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [255:0]                     out_data,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
    output logic                             err
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W   = (FRESH_CYCLES > 1) ? $clog2(FRESH_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   FRESH_LOAD = CNT_W'(FRESH_CYCLES - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);

    sampler_state_e   state;
    nonce_mode_e      mode_q;
    logic [CNT_W-1:0] cnt;
    logic [255:0]     cand;
    logic [255:0]     masked;
    logic             cand_ok;

    assign masked = cand & MASK253;

    ed25519_lt_l u_lt_l (
        .m  (masked[252:0]),
        .ok (cand_ok)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= CLAMP;
            out_valid <= 1'b0;
            err       <= 1'b0;
            out_data  <= '0;
            tries     <= '0;
            cnt       <= '0;
            cand      <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mode_q <= nonce_mode_e'(mode);
                        tries  <= '0;
                        cnt    <= FRESH_LOAD;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cand  <= rng_data;
                        tries <= tries + 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mode_q == CLAMP) begin
                        out_data  <= (cand & CLAMP_CLR) | CLAMP_SET;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (cand_ok) begin
                        out_data  <= masked;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tries == TRIES_MAX) begin
                        // out_data deliberately keeps its previous value
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt   <= FRESH_LOAD;
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
